apmu_ibex_pmu_counter_pipe: RTL

APMU_IBEX_PMU_COUNTER_PIPE -- requirements
Module: apmu_ibex_pmu_counter_pipe

---
 rtl/apmu_ibex_pmu_counter_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/apmu_ibex_pmu_counter_pipe.sv
// Ibex PMU counter-access pipe: issues PMC_REQ/WFP/WFO to the counter block,
// tracks in-flight reads/writes and turns responses into write-back/un-stall pulses.
package ibex_pkg;
  typedef enum logic [1:0] {
    PMC_IDLE = 2'b00,
    PMC_REQ  = 2'b01,
    PMC_WFP  = 2'b10,
    PMC_WFO  = 2'b11
  } pmc_op_e;
endpackage

module apmu_ibex_pmu_counter_pipe
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,

  input  logic                                 pmc_req_i,
  input  pmc_op_e                              pmc_op_i,
  input  logic                                 pmc_we_i,
  input  logic [DataWidth-1:0]                 pmc_wdata_i,
  input  logic [31:0]                          adder_result_ex_i,
  output logic                                 pmc_gnt_o,
  output logic [DataWidth-1:0]                 pmc_rdata_o,
  output logic                                 pmc_rdata_valid_o,
  output logic                                 pmc_resp_valid_o,
  output logic                                 pmc_err_o,
  output logic                                 pmc_timeout_o,
  output logic                                 pmc_spurious_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]  pmc_outstanding_o,

  output pmc_op_e                              counter_op_o,
  output logic [31:0]                          counter_addr_o,
  output logic                                 counter_we_o,
  output logic [DataWidth-1:0]                 counter_wdata_o,
  input  logic                                 counter_gnt_i,
  input  logic                                 counter_rvalid_i,
  input  logic                                 counter_err_i,
  input  logic [DataWidth-1:0]                 counter_rdata_i
);

  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned TimerW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned TimeoutLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutLast);
  localparam logic [CntW-1:0]   CntMax    = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0]   PtrLast   = PtrW'(MaxOutstanding - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RW   = 2'b01,
    S_WFX  = 2'b10
  } state_e;

  state_e                state_q;
  pmc_op_e               wfx_op_q;
  logic [CntW-1:0]       count_q, count_d;
  logic [TimerW-1:0]     timer_q;
  logic [MaxOutstanding-1:0] we_fifo_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;

  logic in_idle, in_rw, in_wfx;
  logic is_wait_op;
  logic req_ok, wait_ok, req_accept, wait_accept;
  logic rvalid, rsp_rw, rsp_wfx, timeout_hit, wfx_done;
  logic head_we;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign in_idle    = (state_q == S_IDLE);
  assign in_rw      = (state_q == S_RW);
  assign in_wfx     = (state_q == S_WFX);
  assign is_wait_op = (pmc_op_i == PMC_WFP) || (pmc_op_i == PMC_WFO);

  // Every decision is qualified by rst_ni so all pulses and the grant drop
  // the moment reset asserts, not at the next edge.
  assign req_ok      = rst_ni && pmc_req_i && (pmc_op_i == PMC_REQ) &&
                       (in_idle || in_rw) && (count_q < CntMax);
  assign wait_ok     = rst_ni && pmc_req_i && is_wait_op && in_idle;
  assign req_accept  = req_ok && counter_gnt_i;
  assign wait_accept = wait_ok && counter_gnt_i;

  assign rvalid      = rst_ni && counter_rvalid_i;
  assign rsp_rw      = rvalid && in_rw;
  assign rsp_wfx     = rvalid && in_wfx;
  assign timeout_hit = rst_ni && in_wfx && !counter_rvalid_i &&
                       (TimeoutCycles != 0) && (timer_q == TimerLast);
  assign wfx_done    = rsp_wfx || timeout_hit;
  assign head_we     = we_fifo_q[rd_ptr_q];

  // A full pipe never bypasses a same-cycle response into a new grant.
  assign count_d = count_q + CntW'(req_accept) - CntW'(rsp_rw);

  assign pmc_gnt_o         = req_accept || wait_accept;
  assign pmc_resp_valid_o  = rsp_rw || rsp_wfx || timeout_hit;
  assign pmc_rdata_valid_o = (rsp_rw && !head_we && !counter_err_i) ||
                             (rsp_wfx && !counter_err_i) || timeout_hit;
  assign pmc_err_o         = (rsp_rw || rsp_wfx) && counter_err_i;
  assign pmc_timeout_o     = timeout_hit;
  assign pmc_spurious_o    = rvalid && in_idle;
  assign pmc_rdata_o       = timeout_hit ? '0 : counter_rdata_i;
  assign pmc_outstanding_o = count_q;

  assign counter_addr_o  = adder_result_ex_i;
  assign counter_we_o    = pmc_we_i;
  assign counter_wdata_o = pmc_wdata_i;

  always_comb begin
    // NOTE: default assigned first so no path through the block leaves the
    // output unassigned, which would otherwise infer a latch.
    counter_op_o = PMC_IDLE;
    if (in_wfx) begin
      if (!wfx_done) counter_op_o = wfx_op_q;
    end else if (req_ok || wait_ok) begin
      counter_op_o = pmc_op_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      wfx_op_q  <= PMC_IDLE;
      count_q   <= '0;
      timer_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      // NOTE: the we-FIFO is only a few flops, so it is reset along with its
      // pointers; a stale head can then never leak into a post-reset decode.
      we_fifo_q <= '0;
    end else begin
      count_q <= count_d;
      if (req_accept) begin
        we_fifo_q[wr_ptr_q] <= pmc_we_i;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (rsp_rw) rd_ptr_q <= ptr_inc(rd_ptr_q);

      unique case (state_q)
        S_IDLE: begin
          if (req_accept) begin
            state_q <= S_RW;
          end else if (wait_accept) begin
            state_q  <= S_WFX;
            wfx_op_q <= pmc_op_i;
            timer_q  <= '0;
          end
        end
        S_RW: begin
          if (count_d == '0) state_q <= S_IDLE;
        end
        S_WFX: begin
          if (wfx_done) begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end else if (TimeoutCycles != 0) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
